// File: rtl/screen_sequencer.sv
// Game-phase sequencer: START/PLAY/WIN/LOSE with screen changes committed only at vblnk rise.
// Also times the end screens in displayed frames and keeps saturating win/loss tallies.
module screen_sequencer #(
    parameter int unsigned END_HOLD_FRAMES = 180,
    parameter int unsigned MIN_SKIP_FRAMES = 30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vblnk_i,
    input  logic       btn_start_i,
    input  logic       round_done_i,
    input  logic       round_win_i,
    output logic [1:0] screen_sel_o,
    output logic       round_active_o,
    output logic       screen_changed_o,
    output logic [3:0] wins_o,
    output logic [3:0] losses_o
);

    // Encoding equals the screen_sel code, so committing a screen is a plain copy.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_e;

    localparam logic [9:0] HOLD_LAST = 10'(END_HOLD_FRAMES - 1);
    localparam logic [9:0] MIN_SKIP  = 10'(MIN_SKIP_FRAMES);

    state_e     state_q, state_d;
    logic [1:0] screen_sel_q, screen_sel_d;
    logic       round_active_q, round_active_d;
    logic       screen_changed_q, screen_changed_d;
    logic [3:0] wins_q, wins_d;
    logic [3:0] losses_q, losses_d;
    logic [9:0] hold_q, hold_d;
    logic       vblnk_q;
    logic       btn_q;

    logic frame_tick;
    logic btn_rise;
    logic in_end_screen;

    assign frame_tick    = vblnk_i & ~vblnk_q;
    assign btn_rise      = btn_start_i & ~btn_q;
    assign in_end_screen = (state_q == ST_WIN) || (state_q == ST_LOSE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_START;
            screen_sel_q     <= 2'd0;
            round_active_q   <= 1'b0;
            screen_changed_q <= 1'b0;
            wins_q           <= 4'd0;
            losses_q         <= 4'd0;
            hold_q           <= 10'd0;
            vblnk_q          <= 1'b1;
            btn_q            <= 1'b1;
        end else begin
            state_q          <= state_d;
            screen_sel_q     <= screen_sel_d;
            round_active_q   <= round_active_d;
            screen_changed_q <= screen_changed_d;
            wins_q           <= wins_d;
            losses_q         <= losses_d;
            hold_q           <= hold_d;
            vblnk_q          <= vblnk_i;
            btn_q            <= btn_start_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: if (btn_rise) state_d = ST_PLAY;
            ST_PLAY:  if (round_done_i) state_d = round_win_i ? ST_WIN : ST_LOSE;
            ST_WIN, ST_LOSE: begin
                if ((frame_tick && (hold_q == HOLD_LAST)) ||
                    (btn_rise && (hold_q >= MIN_SKIP)))
                    state_d = ST_START;
            end
            default:  state_d = ST_START;
        endcase
    end

    always_comb begin
        screen_sel_d     = screen_sel_q;
        screen_changed_d = 1'b0;
        round_active_d   = (state_d == ST_PLAY);
        wins_d           = wins_q;
        losses_d         = losses_q;
        hold_d           = hold_q;

        // The pre-transition state is what gets shown; a same-cycle change waits a frame.
        if (frame_tick) begin
            screen_sel_d     = state_q;
            screen_changed_d = (state_q != screen_sel_q);
        end

        if ((state_q == ST_PLAY) && round_done_i) begin
            hold_d = 10'd0;
            if (round_win_i) begin
                if (wins_q != 4'hF) wins_d = wins_q + 4'd1;
            end else begin
                if (losses_q != 4'hF) losses_d = losses_q + 4'd1;
            end
        end else if (in_end_screen && frame_tick && (screen_sel_q == state_q) &&
                     (state_d == state_q)) begin
            hold_d = hold_q + 10'd1;
        end
    end

    assign screen_sel_o     = screen_sel_q;
    assign round_active_o   = round_active_q;
    assign screen_changed_o = screen_changed_q;
    assign wins_o           = wins_q;
    assign losses_o         = losses_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: a frame-level model predicts screen commits and tallies.
module tb_screen_sequencer;

    localparam int END_HOLD = 4;
    localparam int MIN_SKIP = 2;
    localparam int FRAME    = 20;

    logic       clk = 1'b0;
    logic       rst, vblnk, btn_start, round_done, round_win;
    logic [1:0] screen_sel;
    logic       round_active, screen_changed;
    logic [3:0] wins, losses;

    screen_sequencer #(.END_HOLD_FRAMES(END_HOLD), .MIN_SKIP_FRAMES(MIN_SKIP)) dut (
        .clk_i(clk), .rst_i(rst), .vblnk_i(vblnk), .btn_start_i(btn_start),
        .round_done_i(round_done), .round_win_i(round_win),
        .screen_sel_o(screen_sel), .round_active_o(round_active),
        .screen_changed_o(screen_changed), .wins_o(wins), .losses_o(losses)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int sel; } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int fpos = FRAME - 4;

    // Reference model: game phase, displayed screen, displayed frames in end screen.
    int m_phase = 0, m_disp = 0, m_frames = 0, m_wins = 0, m_losses = 0;
    bit m_active = 0, m_vb_prev = 1, m_btn_prev = 1;

    task automatic check_eq(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic model(input bit r, input bit vb, input bit b, input bit d, input bit w);
        bit tick, rise;
        int old_phase, old_disp;
        if (r) begin
            m_phase = 0; m_disp = 0; m_frames = 0; m_wins = 0; m_losses = 0;
            m_active = 0; m_vb_prev = 1; m_btn_prev = 1;
            return;
        end
        tick = vb && !m_vb_prev;
        rise = b && !m_btn_prev;
        old_phase = m_phase;
        old_disp = m_disp;
        if (m_phase == 0) begin
            if (rise) m_phase = 1;
        end else if (m_phase == 1) begin
            if (d) begin
                m_frames = 0;
                if (w) begin m_phase = 2; if (m_wins < 15) m_wins++; end
                else begin m_phase = 3; if (m_losses < 15) m_losses++; end
            end
        end else begin
            if ((tick && m_frames == END_HOLD - 1) || (rise && m_frames >= MIN_SKIP))
                m_phase = 0;
            else if (tick && old_disp == m_phase)
                m_frames++;
        end
        if (tick) begin
            m_disp = old_phase;
            if (m_disp != old_disp) exp_q.push_back('{cyc: cyc + 1, sel: m_disp});
        end
        m_active = (m_phase == 1);
        m_vb_prev = vb;
        m_btn_prev = b;
    endtask

    task automatic step(input bit r, input bit b, input bit d, input bit w);
        bit vb;
        @(negedge clk);
        vb = (fpos >= FRAME - 4);
        fpos = (fpos + 1) % FRAME;
        rst = r; vblnk = vb; btn_start = b; round_done = d; round_win = w;
        model(r, vb, b, d, w);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        check_eq("round_active", int'(round_active), int'(m_active));
        check_eq("wins", int'(wins), m_wins);
        check_eq("losses", int'(losses), m_losses);
        check_eq("screen_sel", int'(screen_sel), m_disp);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            tests++; failed++;
            $display("FAIL missed_pulse: no screen_changed at cycle %0d for screen %0d", e.cyc, e.sel);
        end
        if (screen_changed) begin
            if (exp_q.size() == 0) begin
                tests++; failed++;
                $display("FAIL spurious_pulse at cycle %0d: screen_sel=%0d, none expected",
                         cyc, screen_sel);
            end else begin
                e = exp_q.pop_front();
                check_eq("pulse_cycle", cyc, e.cyc);
                check_eq("pulse_sel", int'(screen_sel), e.sel);
            end
        end
    end

    initial begin
        bit bv;
        rst = 1; vblnk = 1; btn_start = 1; round_done = 0; round_win = 0;

        // Button and vblnk held through reset: no start, no tick.
        repeat (3) step(1, 1, 0, 0);
        repeat (3 * FRAME) step(0, 1, 0, 0);
        check_eq("idle_sel", int'(screen_sel), 0);

        // Mid-frame press starts a round.
        repeat (7) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check_eq("active_after_press", int'(round_active), 1);
        repeat (FRAME + 5) step(0, 1, 0, 0);
        check_eq("play_sel", int'(screen_sel), 1);

        // round_done beats a simultaneous button rise.
        step(0, 0, 0, 0);
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        check_eq("win_tally", int'(wins), 1);
        check_eq("win_inactive", int'(round_active), 0);

        // Early press in WIN is dropped, then auto-return.
        repeat (2 * FRAME) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (7 * FRAME) step(0, 1, 0, 0);
        check_eq("auto_return_sel", int'(screen_sel), 0);

        // LOSE skipped by a late press.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        repeat (4 * FRAME) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (2 * FRAME) step(0, 1, 0, 0);
        check_eq("lose_tally", int'(losses), 1);
        check_eq("skip_sel", int'(screen_sel), 0);

        // Saturate the win tally.
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 0, 0);
            step(0, 1, 0, 0);
            repeat (2) step(0, 1, 0, 0);
            step(0, 1, 1, 1);
            repeat (7 * FRAME) step(0, 0, 0, 0);
        end
        check_eq("wins_saturated", int'(wins), 15);

        // Reset mid-PLAY clears everything immediately.
        step(0, 1, 0, 0);
        repeat (FRAME) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check_eq("rst_sel", int'(screen_sel), 0);
        check_eq("rst_wins", int'(wins), 0);
        check_eq("rst_active", int'(round_active), 0);

        // Randomized traffic.
        bv = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bv = ~bv;
            step($urandom_range(0, 599) == 0, bv, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)));
        end

        repeat (3) step(0, bv, 0, 0);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
